// File: rtl/pipe_pkg.sv
// Shared types for the F/D/E/M/W hazard controller: forwarding selects, controller states, helpers.
// Pure definitions, no logic of its own.
package pipe_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALT,
        STEP
    } ctrl_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // The M stage holds the younger result, so it wins over W.
    function automatic fwd_sel_t fwd_select(
        input logic [4:0] src,
        input logic       reg_write_m,
        input logic [4:0] write_reg_m,
        input logic       reg_write_w,
        input logic [4:0] write_reg_w
    );
        if (reg_write_m && (write_reg_m != REG_ZERO) && (write_reg_m == src)) begin
            return FWD_M;
        end
        if (reg_write_w && (write_reg_w != REG_ZERO) && (write_reg_w == src)) begin
            return FWD_W;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard controller (slave).
// Master drives register fields, write enables and debug requests; slave returns selects, enables and counters.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
) ();
    import pipe_pkg::*;

    logic [4:0]       rs_D;
    logic [4:0]       rt_D;
    logic [4:0]       rs_E;
    logic [4:0]       rt_E;
    logic [4:0]       write_reg_E;
    logic [4:0]       write_reg_M;
    logic [4:0]       write_reg_W;
    logic             reg_write_E;
    logic             reg_write_M;
    logic             reg_write_W;
    logic             mem_to_reg_E;
    logic             pc_src_M;
    logic             halt_req;
    logic             step_req;

    fwd_sel_t         forward_a_E;
    fwd_sel_t         forward_b_E;
    logic             stall_F;
    logic             stall_D;
    logic             flush_D;
    logic             flush_E;
    logic             flush_M;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output rs_D, rt_D, rs_E, rt_E,
        output write_reg_E, write_reg_M, write_reg_W,
        output reg_write_E, reg_write_M, reg_write_W,
        output mem_to_reg_E, pc_src_M, halt_req, step_req,
        input  forward_a_E, forward_b_E,
        input  stall_F, stall_D, flush_D, flush_E, flush_M,
        input  halted, stall_cnt, flush_cnt
    );

    modport slave (
        input  rs_D, rt_D, rs_E, rt_E,
        input  write_reg_E, write_reg_M, write_reg_W,
        input  reg_write_E, reg_write_M, reg_write_W,
        input  mem_to_reg_E, pc_src_M, halt_req, step_req,
        output forward_a_E, forward_b_E,
        output stall_F, stall_D, flush_D, flush_E, flush_M,
        output halted, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_fwd_unit.sv
// E-stage operand forwarding selects and load-use hazard detect; purely combinational.
// Zero latency; no backpressure of its own, lwstall is consumed by the controller.
module hazard_fwd_unit
    import pipe_pkg::*;
(
    input  logic [4:0] rs_D,
    input  logic [4:0] rt_D,
    input  logic [4:0] rs_E,
    input  logic [4:0] rt_E,
    input  logic [4:0] write_reg_M,
    input  logic [4:0] write_reg_W,
    input  logic       reg_write_E,
    input  logic       reg_write_M,
    input  logic       reg_write_W,
    input  logic       mem_to_reg_E,
    output fwd_sel_t   fwd_a,
    output fwd_sel_t   fwd_b,
    output logic       lwstall
);

    always_comb begin
        fwd_a = fwd_select(rs_E, reg_write_M, write_reg_M, reg_write_W, write_reg_W);
        fwd_b = fwd_select(rt_E, reg_write_M, write_reg_M, reg_write_W, write_reg_W);
        // A load's destination is its rt field while it sits in E.
        lwstall = mem_to_reg_E && reg_write_E && (rt_E != REG_ZERO) &&
                  ((rt_E == rs_D) || (rt_E == rt_D));
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller: forwarding, load-use stall, branch flush, run/drain/halt/step FSM, event counters.
// Stall/flush/forward outputs are same-cycle combinational; halted and counters are registered.
module pipeline_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pipeline_hazard_ctrl_if.slave  hz
);

    localparam logic [2:0]       DCNT_LAST = 3'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    fwd_sel_t         fwd_a;
    fwd_sel_t         fwd_b;
    logic             lwstall;
    logic             branch;
    logic             freeze;

    ctrl_state_t      state_q, state_d;
    logic [2:0]       dcnt_q, dcnt_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic             stall_f_c, stall_d_c, flush_d_c, flush_e_c, flush_m_c;
    logic             unused_write_reg_e;

    assign unused_write_reg_e = ^hz.write_reg_E;

    hazard_fwd_unit u_fwd (
        .rs_D         (hz.rs_D),
        .rt_D         (hz.rt_D),
        .rs_E         (hz.rs_E),
        .rt_E         (hz.rt_E),
        .write_reg_M  (hz.write_reg_M),
        .write_reg_W  (hz.write_reg_W),
        .reg_write_E  (hz.reg_write_E),
        .reg_write_M  (hz.reg_write_M),
        .reg_write_W  (hz.reg_write_W),
        .mem_to_reg_E (hz.mem_to_reg_E),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .lwstall      (lwstall)
    );

    always_comb begin
        branch  = hz.pc_src_M;
        freeze  = (state_q == DRAIN) || (state_q == HALT);
        state_d = state_q;
        dcnt_d  = dcnt_q;

        case (state_q)
            RUN: begin
                if (hz.halt_req) begin
                    state_d = DRAIN;
                    dcnt_d  = 3'd0;
                end
            end
            DRAIN: begin
                // A redirect refills the front end, so the drain has to start over.
                if (!hz.halt_req) begin
                    state_d = RUN;
                end else if (branch) begin
                    dcnt_d = 3'd0;
                end else if (dcnt_q == DCNT_LAST) begin
                    state_d = HALT;
                end else begin
                    dcnt_d = dcnt_q + 3'd1;
                end
            end
            HALT: begin
                if (hz.step_req) begin
                    state_d = STEP;
                end else if (!hz.halt_req) begin
                    state_d = RUN;
                end
            end
            STEP: begin
                if (!(lwstall && !branch)) begin
                    state_d = DRAIN;
                    dcnt_d  = 3'd0;
                end
            end
            default: state_d = RUN;
        endcase

        halted_d = (state_d == HALT);

        if (branch) begin
            stall_f_c = 1'b0;
            stall_d_c = 1'b0;
            flush_d_c = 1'b1;
            flush_e_c = 1'b1;
            flush_m_c = 1'b1;
        end else begin
            stall_f_c = freeze || lwstall;
            stall_d_c = lwstall;
            flush_d_c = freeze;
            flush_e_c = lwstall;
            flush_m_c = 1'b0;
        end

        stall_cnt_d = stall_cnt_q;
        if (lwstall && !branch && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        flush_cnt_d = flush_cnt_q;
        if (branch && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            dcnt_q      <= 3'd0;
            halted_q    <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            dcnt_q      <= dcnt_d;
            halted_q    <= halted_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Combinational outputs are forced quiet while reset is held.
    assign hz.forward_a_E = rst_n ? fwd_a : FWD_RF;
    assign hz.forward_b_E = rst_n ? fwd_b : FWD_RF;
    assign hz.stall_F     = rst_n & stall_f_c;
    assign hz.stall_D     = rst_n & stall_d_c;
    assign hz.flush_D     = rst_n & flush_d_c;
    assign hz.flush_E     = rst_n & flush_e_c;
    assign hz.flush_M     = rst_n & flush_m_c;
    assign hz.halted      = halted_q;
    assign hz.stall_cnt   = stall_cnt_q;
    assign hz.flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: stimulus pushes model predictions, a negedge monitor pops and compares.
module tb_pipeline_hazard_ctrl;
    import pipe_pkg::*;

    localparam int DC   = 4;
    localparam int CW   = 16;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.CNT_W(CW)) hz ();

    pipeline_hazard_ctrl #(.DRAIN_CYCLES(DC), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    typedef struct packed {
        logic [1:0]    fa;
        logic [1:0]    fb;
        logic          sf;
        logic          sd;
        logic          fd;
        logic          fe;
        logic          fm;
        logic          halted;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
    } obs_t;

    obs_t  exp_q[$];
    string tag_q[$];
    string phase = "reset";
    int    n_cmp = 0;
    int    n_bad = 0;

    // Reference model: "draining" with a count of finished drain cycles, halted, stepping.
    bit m_draining, m_halt, m_step;
    int m_done, m_sc, m_fc;

    function automatic logic [1:0] ref_fwd(input logic [4:0] src);
        if (hz.reg_write_M && hz.write_reg_M != 5'd0 && hz.write_reg_M == src) return 2'b10;
        if (hz.reg_write_W && hz.write_reg_W != 5'd0 && hz.write_reg_W == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit ref_lw();
        return hz.mem_to_reg_E && hz.reg_write_E && hz.rt_E != 5'd0 &&
               (hz.rt_E == hz.rs_D || hz.rt_E == hz.rt_D);
    endfunction

    function automatic obs_t ref_out();
        obs_t o;
        bit   lw, frz;
        o = '0;
        if (!rst_n) return o;
        lw  = ref_lw();
        frz = m_draining || m_halt;
        o.fa = ref_fwd(hz.rs_E);
        o.fb = ref_fwd(hz.rt_E);
        if (hz.pc_src_M) begin
            o.fd = 1'b1; o.fe = 1'b1; o.fm = 1'b1;
        end else begin
            o.sf = frz | lw; o.sd = lw; o.fd = frz; o.fe = lw;
        end
        o.halted = m_halt;
        o.sc = m_sc[CW-1:0];
        o.fc = m_fc[CW-1:0];
        return o;
    endfunction

    task automatic model_clear();
        m_draining = 0; m_halt = 0; m_step = 0; m_done = 0; m_sc = 0; m_fc = 0;
    endtask

    task automatic model_edge();
        bit lw, br;
        lw = ref_lw();
        br = hz.pc_src_M;
        if (lw && !br && m_sc < CMAX) m_sc++;
        if (br && m_fc < CMAX) m_fc++;
        if (m_step) begin
            if (!(lw && !br)) begin m_step = 0; m_draining = 1; m_done = 0; end
        end else if (m_halt) begin
            if (hz.step_req) begin m_halt = 0; m_step = 1; end
            else if (!hz.halt_req) m_halt = 0;
        end else if (m_draining) begin
            if (!hz.halt_req) m_draining = 0;
            else if (br) m_done = 0;
            else begin
                m_done++;
                if (m_done == DC) begin m_draining = 0; m_halt = 1; end
            end
        end else if (hz.halt_req) begin
            m_draining = 1; m_done = 0;
        end
    endtask

    task automatic tick();
        exp_q.push_back(ref_out());
        tag_q.push_back(phase);
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    task automatic set_idle();
        hz.rs_D = 0; hz.rt_D = 0; hz.rs_E = 0; hz.rt_E = 0;
        hz.write_reg_E = 0; hz.write_reg_M = 0; hz.write_reg_W = 0;
        hz.reg_write_E = 0; hz.reg_write_M = 0; hz.reg_write_W = 0;
        hz.mem_to_reg_E = 0; hz.pc_src_M = 0; hz.halt_req = 0; hz.step_req = 0;
    endtask

    task automatic set_load_use();
        hz.mem_to_reg_E = 1; hz.reg_write_E = 1; hz.rt_E = 5'd5; hz.write_reg_E = 5'd5; hz.rs_D = 5'd5;
    endtask

    task automatic hold_reset(input int n);
        rst_n = 1'b0;
        model_clear();
        repeat (n) tick();
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        obs_t  e, a;
        string t;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a.fa = hz.forward_a_E; a.fb = hz.forward_b_E;
            a.sf = hz.stall_F; a.sd = hz.stall_D;
            a.fd = hz.flush_D; a.fe = hz.flush_E; a.fm = hz.flush_M;
            a.halted = hz.halted; a.sc = hz.stall_cnt; a.fc = hz.flush_cnt;
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL %s t=%0t got fa=%b fb=%b sF=%b sD=%b fD=%b fE=%b fM=%b h=%b sc=%0d fc=%0d, expected fa=%b fb=%b sF=%b sD=%b fD=%b fE=%b fM=%b h=%b sc=%0d fc=%0d",
                         t, $time, a.fa, a.fb, a.sf, a.sd, a.fd, a.fe, a.fm, a.halted, a.sc, a.fc,
                         e.fa, e.fb, e.sf, e.sd, e.fd, e.fe, e.fm, e.halted, e.sc, e.fc);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        set_idle();
        rst_n = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        hold_reset(3);

        phase = "fwd";
        hz.reg_write_M = 1; hz.write_reg_M = 5'd2; hz.rs_E = 5'd2; tick();
        hz.reg_write_W = 1; hz.write_reg_W = 5'd2; tick();
        hz.reg_write_M = 0; tick();
        hz.reg_write_M = 1; hz.write_reg_M = 5'd0; hz.reg_write_W = 0; hz.rs_E = 5'd0; tick();

        phase = "load_use";
        set_idle();
        hz.mem_to_reg_E = 1; hz.reg_write_E = 1; hz.rt_E = 5'd3; hz.rs_D = 5'd3; tick();
        hz.mem_to_reg_E = 0; hz.reg_write_E = 0; hz.rt_E = 0;
        hz.reg_write_M = 1; hz.write_reg_M = 5'd3; tick();
        hz.reg_write_M = 0; hz.reg_write_W = 1; hz.write_reg_W = 5'd3; hz.rs_E = 5'd3; tick();

        phase = "branch_over_lw";
        set_idle(); set_load_use(); hz.pc_src_M = 1; tick();
        set_idle(); tick();

        phase = "halt";
        hz.halt_req = 1; repeat (7) tick();
        hz.halt_req = 0; repeat (2) tick();

        phase = "step";
        hz.halt_req = 1; repeat (7) tick();
        hz.step_req = 1; tick();
        hz.step_req = 0; repeat (7) tick();
        hz.halt_req = 0; repeat (2) tick();

        phase = "random";
        repeat (3000) begin
            hz.rs_D = 5'($urandom_range(0, 3)); hz.rt_D = 5'($urandom_range(0, 3));
            hz.rs_E = 5'($urandom_range(0, 3)); hz.rt_E = 5'($urandom_range(0, 3));
            hz.write_reg_E = 5'($urandom_range(0, 3));
            hz.write_reg_M = 5'($urandom_range(0, 3)); hz.write_reg_W = 5'($urandom_range(0, 3));
            hz.reg_write_E = 1'($urandom_range(0, 1)); hz.reg_write_M = 1'($urandom_range(0, 1));
            hz.reg_write_W = 1'($urandom_range(0, 1)); hz.mem_to_reg_E = 1'($urandom_range(0, 1));
            hz.pc_src_M = ($urandom_range(0, 7) == 0);
            hz.step_req = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 15) == 0) hz.halt_req = ~hz.halt_req;
            tick();
        end

        phase = "reset_mid_drain";
        set_idle(); hz.halt_req = 1; repeat (3) tick();
        set_load_use(); hz.reg_write_M = 1; hz.write_reg_M = 5'd1; hz.rs_E = 5'd1;
        hold_reset(2);
        repeat (3) tick();
        set_idle(); repeat (2) tick();

        phase = "stall_saturate";
        set_load_use();
        repeat (CMAX + 4) tick();
        set_idle(); tick();

        phase = "drained";
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drained: %0d expectations left unchecked, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
